// File: rtl/hwpe_stream_serialize_reg.sv
// Merges NB_IN_STREAMS input streams into one output stream, taking nb_contig_m1+1 beats
// from each input in round-robin order, through a one-entry registered output buffer.
module hwpe_stream_serialize_reg #(
  parameter int unsigned NB_IN_STREAMS = 2,
  parameter int unsigned CONTIG_LIMIT  = 1024,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    clear_i,
  input  logic [15:0]                             ctrl_first_stream_i,
  input  logic                                    ctrl_clear_serdes_state_i,
  input  logic [15:0]                             ctrl_nb_contig_m1_i,
  input  logic [NB_IN_STREAMS*DATA_WIDTH-1:0]     push_data_i,
  input  logic [NB_IN_STREAMS*DATA_WIDTH/8-1:0]   push_strb_i,
  input  logic [NB_IN_STREAMS-1:0]                push_valid_i,
  output logic [NB_IN_STREAMS-1:0]                push_ready_o,
  output logic [DATA_WIDTH-1:0]                   pop_data_o,
  output logic [DATA_WIDTH/8-1:0]                 pop_strb_o,
  output logic                                    pop_valid_o,
  input  logic                                    pop_ready_i
);

  localparam int unsigned SW     = $clog2(NB_IN_STREAMS);
  localparam int unsigned CW     = $clog2(CONTIG_LIMIT);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [SW-1:0]         stream_cnt_q;
  logic [CW-1:0]         contig_cnt_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [STRB_W-1:0]     out_strb_q;

  logic                  in_ready;
  logic                  in_hs;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [STRB_W-1:0]     sel_strb;
  logic [CW-1:0]         nb_contig_m1;
  logic [SW-1:0]         first_stream;
  logic                  burst_end;
  logic                  last_stream;

  // No handshake is offered while the block is being reset or cleared.
  assign in_ready = ~(rst_i | clear_i) & (~out_valid_q | pop_ready_i);
  assign in_hs    = sel_valid & in_ready;

  always_comb begin
    sel_valid    = 1'b0;
    sel_data     = '0;
    sel_strb     = '0;
    push_ready_o = '0;
    for (int unsigned k = 0; k < NB_IN_STREAMS; k++) begin
      if (stream_cnt_q == SW'(k)) begin
        sel_valid       = push_valid_i[k];
        sel_data        = push_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_strb        = push_strb_i[k*STRB_W +: STRB_W];
        push_ready_o[k] = in_ready;
      end
    end
  end

  assign nb_contig_m1 = ctrl_nb_contig_m1_i[CW-1:0];
  assign first_stream = (ctrl_first_stream_i >= 16'(NB_IN_STREAMS)) ? '0
                                                                    : ctrl_first_stream_i[SW-1:0];
  assign burst_end    = contig_cnt_q >= nb_contig_m1;
  assign last_stream  = stream_cnt_q == SW'(NB_IN_STREAMS - 1);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      stream_cnt_q <= '0;
      contig_cnt_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
    end else begin
      if (in_hs) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_strb_q  <= sel_strb;
      end else if (pop_ready_i) begin
        out_valid_q <= 1'b0;
      end

      if (ctrl_clear_serdes_state_i) begin
        stream_cnt_q <= first_stream;
        contig_cnt_q <= '0;
      end else if (in_hs && burst_end) begin
        contig_cnt_q <= '0;
        stream_cnt_q <= last_stream ? '0 : stream_cnt_q + 1'b1;
      end else if (in_hs) begin
        contig_cnt_q <= contig_cnt_q + 1'b1;
      end
    end
  end

  assign pop_valid_o = out_valid_q;
  assign pop_data_o  = out_data_q;
  assign pop_strb_o  = out_strb_q;

endmodule

// File: tb/tb_hwpe_stream_serialize_reg.sv
// Directed bench for hwpe_stream_serialize_reg with three inputs and a 16-beat contig limit.
module tb_hwpe_stream_serialize_reg;

  localparam int unsigned N  = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned SB = DW / 8;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              clear_i = 1'b0;
  logic [15:0]       ctrl_first_stream_i = '0;
  logic              ctrl_clear_serdes_state_i = 1'b0;
  logic [15:0]       ctrl_nb_contig_m1_i = '0;
  logic [N*DW-1:0]   push_data_i = '0;
  logic [N*SB-1:0]   push_strb_i = '0;
  logic [N-1:0]      push_valid_i = '0;
  logic [N-1:0]      push_ready_o;
  logic [DW-1:0]     pop_data_o;
  logic [SB-1:0]     pop_strb_o;
  logic              pop_valid_o;
  logic              pop_ready_i = 1'b1;

  hwpe_stream_serialize_reg #(
    .NB_IN_STREAMS(N),
    .CONTIG_LIMIT (16),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst_i),
    .clear_i                  (clear_i),
    .ctrl_first_stream_i      (ctrl_first_stream_i),
    .ctrl_clear_serdes_state_i(ctrl_clear_serdes_state_i),
    .ctrl_nb_contig_m1_i      (ctrl_nb_contig_m1_i),
    .push_data_i              (push_data_i),
    .push_strb_i              (push_strb_i),
    .push_valid_i             (push_valid_i),
    .push_ready_o             (push_ready_o),
    .pop_data_o               (pop_data_o),
    .pop_strb_o               (pop_strb_o),
    .pop_valid_o              (pop_valid_o),
    .pop_ready_i              (pop_ready_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int idx[N];
  int eidx[N];
  int hs_count;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int s, input int i);
    logic [7:0] hi;
    hi = 8'hA0 + 8'(s) * 8'h10;
    return {hi, 16'h0000, 8'(i)};
  endfunction

  function automatic logic [SB-1:0] mkstrb(input int s, input int i);
    return SB'(i + s + 1);
  endfunction

  task automatic update_data();
    for (int s = 0; s < N; s++) begin
      push_data_i[s*DW +: DW] = mkdata(s, idx[s]);
      push_strb_i[s*SB +: SB] = mkstrb(s, idx[s]);
    end
  endtask

  // One clock: observe handshakes mid-cycle, advance sources just after the edge.
  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = push_valid_i & push_ready_o;
    if (pop_valid_o && pop_ready_i) got_q.push_back(pop_data_o);
    @(posedge clk);
    #1;
    for (int s = 0; s < N; s++) begin
      if (hs[s]) begin
        idx[s]++;
        hs_count++;
      end
    end
    update_data();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_beat(input int s);
    exp_q.push_back(mkdata(s, eidx[s]));
    eidx[s]++;
  endtask

  task automatic drain_and_compare(input string tag);
    push_valid_i = '0;
    ticks(2);
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic phase_start();
    push_valid_i = '0;
    ctrl_clear_serdes_state_i = 1'b0;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int s = 0; s < N; s++) begin
      idx[s]  = 0;
      eidx[s] = 0;
    end
    hs_count = 0;
    got_q.delete();
    exp_q.delete();
    update_data();
    #1;
  endtask

  initial begin
    for (int s = 0; s < N; s++) begin
      idx[s]  = 0;
      eidx[s] = 0;
    end
    hs_count = 0;
    update_data();

    // Reset values
    ticks(2);
    check("rst_ready", 64'(push_ready_o), 64'h0);
    rst_i = 1'b0;
    #1;
    check("rst_valid", 64'(pop_valid_o), 64'h0);
    check("rst_data", 64'(pop_data_o), 64'h0);
    check("rst_strb", 64'(pop_strb_o), 64'h0);
    check("rst_sel", 64'(push_ready_o), 64'b001);

    // Per-beat interleave, full throughput
    phase_start();
    ctrl_nb_contig_m1_i = 16'd0;
    push_valid_i = '1;
    tick();
    check("t1_first_valid", 64'(pop_valid_o), 64'h1);
    check("t1_first_data", 64'(pop_data_o), 64'hA000_0000);
    check("t1_first_strb", 64'(pop_strb_o), 64'(mkstrb(0, 0)));
    ticks(8);
    check("t1_hs_count", 64'(hs_count), 64'd9);
    for (int i = 0; i < 9; i++) expect_beat(i % 3);
    drain_and_compare("t1");

    // 4-beat bursts with wrap back to stream 0
    phase_start();
    ctrl_nb_contig_m1_i = 16'd3;
    push_valid_i = '1;
    ticks(16);
    for (int i = 0; i < 16; i++) expect_beat((i / 4) % 3);
    drain_and_compare("t2");

    // Backpressure: pop ready 1,0,0,1
    phase_start();
    ctrl_nb_contig_m1_i = 16'd0;
    push_valid_i = '1;
    tick();
    pop_ready_i = 1'b0;
    #1;
    check("t3_stall_ready", 64'(push_ready_o), 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("t3_stall%0d_valid", i), 64'(pop_valid_o), 64'h1);
      check($sformatf("t3_stall%0d_data", i), 64'(pop_data_o), 64'hA000_0000);
      check($sformatf("t3_stall%0d_ready", i), 64'(push_ready_o), 64'h0);
    end
    pop_ready_i = 1'b1;
    ticks(3);
    for (int i = 0; i < 4; i++) expect_beat(i % 3);
    drain_and_compare("t3");

    // clear_serdes_state mid-burst, plus out-of-range first_stream
    phase_start();
    ctrl_nb_contig_m1_i = 16'd3;
    push_valid_i = '1;
    ticks(2);
    ctrl_first_stream_i = 16'd1;
    ctrl_clear_serdes_state_i = 1'b1;
    tick();
    ctrl_clear_serdes_state_i = 1'b0;
    #1;
    check("t4_sel_s1", 64'(push_ready_o), 64'b010);
    ticks(5);
    for (int i = 0; i < 3; i++) expect_beat(0);
    for (int i = 0; i < 4; i++) expect_beat(1);
    expect_beat(2);
    drain_and_compare("t4");
    ctrl_clear_serdes_state_i = 1'b1;
    ctrl_first_stream_i = 16'd2;
    tick();
    check("t4_first2", 64'(push_ready_o), 64'b100);
    ctrl_first_stream_i = 16'd5;
    tick();
    check("t4_first5", 64'(push_ready_o), 64'b001);
    ctrl_first_stream_i = 16'd2;
    tick();
    ctrl_first_stream_i = 16'd3;
    tick();
    check("t4_first3", 64'(push_ready_o), 64'b001);
    ctrl_clear_serdes_state_i = 1'b0;
    ctrl_first_stream_i = 16'd0;

    // clear_i and rst_i with a full buffer
    phase_start();
    ctrl_nb_contig_m1_i = 16'd0;
    pop_ready_i = 1'b0;
    push_valid_i = '1;
    tick();
    check("t5_loaded", 64'(pop_valid_o), 64'h1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    #1;
    check("t5_clr_valid", 64'(pop_valid_o), 64'h0);
    check("t5_clr_data", 64'(pop_data_o), 64'h0);
    check("t5_clr_sel", 64'(push_ready_o), 64'b001);
    tick();
    check("t5_reload", 64'(pop_valid_o), 64'h1);
    check("t5_reload_data", 64'(pop_data_o), 64'hA000_0001);
    rst_i = 1'b1;
    #1;
    check("t5_rst_ready", 64'(push_ready_o), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_rst%0d_ready", i), 64'(push_ready_o), 64'h0);
      check($sformatf("t5_rst%0d_valid", i), 64'(pop_valid_o), 64'h0);
    end
    rst_i = 1'b0;
    #1;
    check("t5_post_rst_sel", 64'(push_ready_o), 64'b001);
    check("t5_post_rst_data", 64'(pop_data_o), 64'h0);
    pop_ready_i = 1'b1;

    // Lowering nb_contig_m1 mid-burst ends the burst at the next handshake
    phase_start();
    ctrl_nb_contig_m1_i = 16'd7;
    push_valid_i = '1;
    ticks(4);
    ctrl_nb_contig_m1_i = 16'd1;
    ticks(4);
    for (int i = 0; i < 5; i++) expect_beat(0);
    expect_beat(1);
    expect_beat(1);
    expect_beat(2);
    drain_and_compare("t6");

    // nb_contig_m1 truncated to counter width: 17 behaves as 1
    phase_start();
    ctrl_nb_contig_m1_i = 16'd17;
    push_valid_i = '1;
    ticks(4);
    expect_beat(0);
    expect_beat(0);
    expect_beat(1);
    expect_beat(1);
    drain_and_compare("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
